// File: rtl/sipo_frame_ctrl.sv
// Sequencing controller for a WIDTH-bit serial-in/parallel-out shift register.
// Frames serial bits into words and hands them downstream over valid/ready.
module sipo_frame_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CONTINUOUS = 0,
    parameter int CNT_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             sipo_shift_en,
    output logic             sipo_clr,
    output logic             sipo_serial_in,
    input  logic [WIDTH-1:0] sipo_q,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [CNT_W-1:0]   bit_cnt_next;
    logic [WIDTH-1:0]   data_out_reg;
    logic [WIDTH-1:0]   data_out_next;
    logic               data_valid_reg;
    logic               data_valid_next;
    logic               overrun_reg;
    logic               overrun_next;

    logic               last_bit;
    logic               capture_load;
    logic               capture_drop;

    assign last_bit = (bit_cnt_reg == CNT_W'(WIDTH - 1));

    // A completed word is only accepted into the holding register when the
    // previous one has left (or is leaving on this very edge).
    assign capture_load = (state_reg == ST_CAPTURE) && (!data_valid_reg || data_ready);
    assign capture_drop = (state_reg == ST_CAPTURE) && data_valid_reg && !data_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sipo_shift_en && last_bit) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (frame_start || (CONTINUOUS != 0)) begin
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic; frame_start blocks shifting so an aborted frame restarts cleanly
    always_comb begin
        bit_ready      = (state_reg == ST_SHIFT) && !frame_start;
        sipo_shift_en  = bit_valid && bit_ready;
        sipo_clr       = frame_start;
        sipo_serial_in = bit_in;
        busy           = (state_reg != ST_IDLE);
    end

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (frame_start) begin
            bit_cnt_next = '0;
        end else if (sipo_shift_en) begin
            bit_cnt_next = last_bit ? '0 : bit_cnt_reg + 1'b1;
        end
    end

    // A load on the same edge as a transfer keeps valid high with the new word
    always_comb begin
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        if (capture_load) begin
            data_out_next   = sipo_q;
            data_valid_next = 1'b1;
        end else if (data_valid_reg && data_ready) begin
            data_valid_next = 1'b0;
        end
    end

    always_comb begin
        overrun_next = overrun_reg;
        if (capture_drop) begin
            overrun_next = 1'b1;
        end else if (ovr_clr) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg    <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            bit_cnt_reg    <= bit_cnt_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign bit_cnt    = bit_cnt_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: one single-shot and one continuous instance share
// stimulus; each drives its own behavioural SIPO and word scoreboard.
module tb_sipo_frame_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          bit_in;
    logic          bit_valid;
    logic          data_ready;
    logic          ovr_clr;

    logic          bit_ready0, shift_en0, clr0, ser0, data_valid0, overrun0, busy0;
    logic          bit_ready1, shift_en1, clr1, ser1, data_valid1, overrun1, busy1;
    logic [W-1:0]  data_out0, data_out1;
    logic [W-1:0]  sq0, sq1;
    logic [CW-1:0] bit_cnt0, bit_cnt1;

    logic [W-1:0]  got0[$];
    logic [W-1:0]  got1[$];

    int checks = 0;
    int errors = 0;

    sipo_frame_ctrl #(.WIDTH(W), .CONTINUOUS(0)) dut0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(bit_ready0), .sipo_shift_en(shift_en0),
        .sipo_clr(clr0), .sipo_serial_in(ser0), .sipo_q(sq0), .data_out(data_out0),
        .data_valid(data_valid0), .data_ready(data_ready), .overrun(overrun0),
        .ovr_clr(ovr_clr), .bit_cnt(bit_cnt0), .busy(busy0)
    );

    sipo_frame_ctrl #(.WIDTH(W), .CONTINUOUS(1)) dut1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(bit_ready1), .sipo_shift_en(shift_en1),
        .sipo_clr(clr1), .sipo_serial_in(ser1), .sipo_q(sq1), .data_out(data_out1),
        .data_valid(data_valid1), .data_ready(data_ready), .overrun(overrun1),
        .ovr_clr(ovr_clr), .bit_cnt(bit_cnt1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MSB-first shift registers modelled behaviourally
    initial begin
        sq0 = '0;
        sq1 = '0;
    end
    always @(posedge clk) begin
        if (clr0) sq0 <= '0;
        else if (shift_en0) sq0 <= {sq0[W-2:0], ser0};
        if (clr1) sq1 <= '0;
        else if (shift_en1) sq1 <= {sq1[W-2:0], ser1};
    end

    // Record every word handed downstream
    always @(negedge clk) begin
        if (!rst && data_valid0 && data_ready) got0.push_back(data_out0);
        if (!rst && data_valid1 && data_ready) got1.push_back(data_out1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; frame_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        data_ready = 1'b1; ovr_clr = 1'b0;
        tick; tick;
        rst = 1'b0;
        got0.delete();
        got1.delete();
    endtask

    task automatic start_frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
    endtask

    // Feed one word MSB first; a bit is consumed only when valid meets ready.
    task automatic drive_word(input logic [W-1:0] w, input int sel, input bit gaps,
                              output int stalls, output int ok);
        int i;
        int cyc;
        logic rdy;
        i = 0; cyc = 0; stalls = 0;
        while (i < W && cyc < 200) begin
            bit_in    = w[W-1-i];
            bit_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            rdy = (sel == 0) ? bit_ready0 : bit_ready1;
            if (bit_valid && rdy) i++;
            else if (!rdy) stalls++;
            tick;
            cyc++;
        end
        bit_valid = 1'b0;
        ok = (i == W) ? 1 : 0;
    endtask

    task automatic test_reset;
        rst = 1'b1; frame_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b1;
        data_ready = 1'b0; ovr_clr = 1'b0;
        #3;
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (bit_cnt0 !== '0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt0); end
        checks++; if (data_out0 !== '0) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out0); end
        checks++; if (data_valid0 !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid0); end
        checks++; if (overrun0 !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun0); end
        checks++; if (bit_ready0 !== 1'b0) begin errors++; $display("FAIL reset_bit_ready: got %b expected 0", bit_ready0); end
        tick; tick;
        rst = 1'b0;
        tick;
        checks++; if (shift_en0 !== 1'b0) begin errors++; $display("FAIL idle_shift_en: got %b expected 0", shift_en0); end
        bit_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_frame;
        logic [W-1:0] w;
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 8'hB3 : 8'($urandom);
            do_reset;
            start_frame;
            #1;
            checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy0); end
            for (int i = 0; i < W; i++) begin
                bit_in = w[W-1-i]; bit_valid = 1'b1;
                #1;
                checks++; if (shift_en0 !== 1'b1 || bit_cnt0 !== CW'(i)) begin
                    errors++; $display("FAIL single_shift bit %0d: got en=%b cnt=%0d expected en=1 cnt=%0d", i, shift_en0, bit_cnt0, i);
                end
                tick;
            end
            bit_valid = 1'b0;
            #1;
            checks++; if (bit_ready0 !== 1'b0 || data_valid0 !== 1'b0) begin
                errors++; $display("FAIL single_capture_cycle: got rdy=%b valid=%b expected 0 0", bit_ready0, data_valid0);
            end
            tick;
            checks++; if (data_valid0 !== 1'b1 || data_out0 !== w) begin
                errors++; $display("FAIL single_word: got valid=%b data=%h expected 1 %h", data_valid0, data_out0, w);
            end
            checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b expected 0", busy0); end
            tick;
            checks++; if (data_valid0 !== 1'b0 || overrun0 !== 1'b0) begin
                errors++; $display("FAIL single_after: got valid=%b ovr=%b expected 0 0", data_valid0, overrun0);
            end
            $display("test_single_frame word %h sent", w);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] w;
        int st, ok;
        do_reset;
        start_frame;
        drive_word(8'hB3, 1, 1'b0, st, ok);
        exp_q.push_back(8'hB3);
        checks++; if (bit_ready1 !== 1'b0) begin errors++; $display("FAIL b2b_capture_rdy: got %b expected 0", bit_ready1); end
        drive_word(8'h5A, 1, 1'b0, st, ok);
        exp_q.push_back(8'h5A);
        checks++; if (st !== 1 || ok !== 1) begin errors++; $display("FAIL b2b_stall: got stalls=%0d ok=%0d expected 1 1", st, ok); end
        for (int k = 0; k < 4; k++) begin
            w = 8'($urandom);
            drive_word(w, 1, 1'b1, st, ok);
            exp_q.push_back(w);
            checks++; if (ok !== 1) begin errors++; $display("FAIL b2b_timeout word %0d: got ok=%0d expected 1", k, ok); end
        end
        tick; tick; tick;
        checks++; if (got1.size() !== exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d words expected %0d", got1.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got1.size(); k++) begin
            checks++; if (got1[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_word %0d: got %h expected %h", k, got1[k], exp_q[k]); end
        end
        checks++; if (overrun1 !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun1); end
        $display("test_back_to_back %0d words", got1.size());
    endtask

    task automatic test_overrun;
        int st, ok;
        do_reset;
        data_ready = 1'b0;
        start_frame;
        drive_word(8'hB3, 1, 1'b0, st, ok);
        drive_word(8'h0F, 1, 1'b1, st, ok);
        checks++; if (data_valid1 !== 1'b1 || data_out1 !== 8'hB3 || overrun1 !== 1'b0) begin
            errors++; $display("FAIL ovr_pending: got valid=%b data=%h ovr=%b expected 1 b3 0", data_valid1, data_out1, overrun1);
        end
        tick;
        checks++; if (overrun1 !== 1'b1 || data_out1 !== 8'hB3) begin
            errors++; $display("FAIL ovr_set: got ovr=%b data=%h expected 1 b3", overrun1, data_out1);
        end
        ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
        checks++; if (overrun1 !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun1); end
        drive_word(8'($urandom), 1, 1'b1, st, ok);
        ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
        checks++; if (overrun1 !== 1'b1 || data_out1 !== 8'hB3) begin
            errors++; $display("FAIL ovr_set_wins: got ovr=%b data=%h expected 1 b3", overrun1, data_out1);
        end
        ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
        data_ready = 1'b1;
        tick;
        checks++; if (data_valid1 !== 1'b0 || overrun1 !== 1'b0) begin
            errors++; $display("FAIL ovr_drain: got valid=%b ovr=%b expected 0 0", data_valid1, overrun1);
        end
        checks++; if (got1.size() !== 1 || (got1.size() > 0 && got1[0] !== 8'hB3)) begin
            errors++; $display("FAIL ovr_delivered: got %0d words expected 1 word b3", got1.size());
        end
        $display("test_overrun done");
    endtask

    task automatic test_abort;
        int st, ok;
        do_reset;
        start_frame;
        for (int i = 0; i < 5; i++) begin
            bit_in = 1'($urandom); bit_valid = 1'b1;
            tick;
        end
        checks++; if (bit_cnt0 !== CW'(5)) begin errors++; $display("FAIL abort_partial_cnt: got %0d expected 5", bit_cnt0); end
        frame_start = 1'b1;
        #1;
        checks++; if (clr0 !== 1'b1 || shift_en0 !== 1'b0 || bit_ready0 !== 1'b0) begin
            errors++; $display("FAIL abort_restart: got clr=%b en=%b rdy=%b expected 1 0 0", clr0, shift_en0, bit_ready0);
        end
        tick;
        frame_start = 1'b0; bit_valid = 1'b0;
        #1;
        checks++; if (bit_cnt0 !== '0 || clr0 !== 1'b0) begin
            errors++; $display("FAIL abort_cnt_zero: got cnt=%0d clr=%b expected 0 0", bit_cnt0, clr0);
        end
        drive_word(8'h3C, 0, 1'b0, st, ok);
        tick;
        checks++; if (data_valid0 !== 1'b1 || data_out0 !== 8'h3C) begin
            errors++; $display("FAIL abort_word: got valid=%b data=%h expected 1 3c", data_valid0, data_out0);
        end
        $display("test_abort done");
    endtask

    task automatic test_reset_mid_frame;
        int st, ok;
        do_reset;
        data_ready = 1'b0;
        start_frame;
        drive_word(8'($urandom), 1, 1'b0, st, ok);
        tick;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'($urandom); bit_valid = 1'b1;
            tick;
        end
        bit_valid = 1'b0;
        checks++; if (bit_cnt1 !== CW'(3) || data_valid1 !== 1'b1) begin
            errors++; $display("FAIL midrst_before: got cnt=%0d valid=%b expected 3 1", bit_cnt1, data_valid1);
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (busy1 !== 1'b0 || bit_cnt1 !== '0 || data_valid1 !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got busy=%b cnt=%0d valid=%b expected 0 0 0", busy1, bit_cnt1, data_valid1);
        end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'($urandom); bit_valid = 1'b1;
            #1;
            checks++; if (shift_en1 !== 1'b0 || busy1 !== 1'b0) begin
                errors++; $display("FAIL midrst_ignored cycle %0d: got en=%b busy=%b expected 0 0", i, shift_en1, busy1);
            end
            tick;
        end
        bit_valid = 1'b0;
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_load_with_transfer;
        logic [W-1:0] w1, w2;
        int st, ok;
        w1 = 8'($urandom);
        w2 = ~w1;
        do_reset;
        data_ready = 1'b0;
        start_frame;
        drive_word(w1, 1, 1'b0, st, ok);
        drive_word(w2, 1, 1'b1, st, ok);
        data_ready = 1'b1;
        tick;
        checks++; if (data_valid1 !== 1'b1 || data_out1 !== w2 || overrun1 !== 1'b0) begin
            errors++; $display("FAIL same_edge_load: got valid=%b data=%h ovr=%b expected 1 %h 0", data_valid1, data_out1, overrun1, w2);
        end
        tick;
        checks++; if (data_valid1 !== 1'b0) begin errors++; $display("FAIL same_edge_drain: got %b expected 0", data_valid1); end
        checks++; if (got1.size() !== 2 || (got1.size() == 2 && (got1[0] !== w1 || got1[1] !== w2))) begin
            errors++; $display("FAIL same_edge_words: got %0d words expected %h %h", got1.size(), w1, w2);
        end
        $display("test_load_with_transfer words %h %h", w1, w2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_overrun;
        test_abort;
        test_reset_mid_frame;
        test_load_with_transfer;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
